// File: rtl/ddr4_bank_cmd_seq.sv
// DDR4 bank command sequencer: open-row table, PRE/ACT/RD/WR issue with tRP/tRCD/CL/CWL timing, PREA+REF refresh.
// Optional DDR4_PERF_CNT_EN builds saturating hit/empty/miss counters; otherwise perf_* are tied to 0.
module ddr4_bank_cmd_seq #(
   parameter int BG_WIDTH  = 2,
   parameter int BA_WIDTH  = 2,
   parameter int ROW_WIDTH = 17,
   parameter int COL_WIDTH = 10,
   parameter int TAG_WIDTH = 4,
   parameter int T_RP      = 16,
   parameter int T_RCD     = 16,
   parameter int T_CL      = 16,
   parameter int T_CWL     = 12,
   parameter int T_BL      = 4,
   parameter int T_RFC     = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_rw,
   input  logic [BG_WIDTH-1:0]  req_bg,
   input  logic [BA_WIDTH-1:0]  req_ba,
   input  logic [ROW_WIDTH-1:0] req_row,
   input  logic [COL_WIDTH-1:0] req_col,
   input  logic                 req_ap,
   input  logic [TAG_WIDTH-1:0] req_tag,
   input  logic                 refresh_req,
   output logic                 refresh_ack,
   output logic                 cmd_valid,
   output logic [2:0]           cmd_op,
   output logic [BG_WIDTH-1:0]  cmd_bg,
   output logic [BA_WIDTH-1:0]  cmd_ba,
   output logic [ROW_WIDTH-1:0] cmd_addr,
   output logic                 done,
   output logic [TAG_WIDTH-1:0] done_tag,
   output logic                 page_hit,
   output logic                 page_empty,
   output logic                 page_miss,
   output logic [31:0]          perf_hit,
   output logic [31:0]          perf_empty,
   output logic [31:0]          perf_miss
);
   localparam int BK_W   = BG_WIDTH + BA_WIDTH;
   localparam int NBANK  = 2**BK_W;
   localparam int RD_LAT = T_CL + T_BL;
   localparam int WR_LAT = T_CWL + T_BL;
   localparam int CNT_W  = $clog2(RD_LAT + WR_LAT + T_RP + T_RCD + T_RFC + 1);

   localparam logic [2:0] OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3,
                          OP_PRE = 3'd4, OP_PREA = 3'd5, OP_REF = 3'd6;

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_DATA,
      S_RPREA, S_RWAIT_RP, S_REF, S_RWAIT_RFC
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NBANK-1:0]     open_q, open_d;
   logic [ROW_WIDTH-1:0] row_q [NBANK];
   logic [ROW_WIDTH-1:0] row_d [NBANK];
   logic                 run_q;
   logic                 hit_q, hit_d, empty_q, empty_d, miss_q, miss_d;
   logic                 ack_q, ack_d;
   logic                 rw_q, rw_d, ap_q, ap_d;
   logic [BK_W-1:0]      bank_q, bank_d;
   logic [ROW_WIDTH-1:0] rrow_q, rrow_d;
   logic [COL_WIDTH-1:0] col_q, col_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;

   logic                 accept, lk_open, lk_hit;
   logic [BK_W-1:0]      req_bank;
   logic [ROW_WIDTH-1:0] col_addr;

   assign req_bank = {req_bg, req_ba};
   assign accept   = req_valid && req_ready;
   assign lk_open  = open_q[req_bank];
   assign lk_hit   = lk_open && (row_q[req_bank] == req_row);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Each wait state is left when the counter reaches 1, so a load of T-1 places the next command T cycles later.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (refresh_req)
               state_d = (|open_q) ? S_RPREA : S_REF;
            else if (accept)
               state_d = !lk_open ? S_ACT : (lk_hit ? S_RW : S_PRE);
         end
         S_PRE:       begin state_d = S_WAIT_RP;  cnt_d = CNT_W'(T_RP - 1);  end
         S_ACT:       begin state_d = S_WAIT_RCD; cnt_d = CNT_W'(T_RCD - 1); end
         S_RW:        begin state_d = S_WAIT_DATA; cnt_d = rw_q ? CNT_W'(RD_LAT) : CNT_W'(WR_LAT); end
         S_RPREA:     begin state_d = S_RWAIT_RP; cnt_d = CNT_W'(T_RP - 1);  end
         S_REF:       begin state_d = S_RWAIT_RFC; cnt_d = CNT_W'(T_RFC - 1); end
         S_WAIT_RP:   begin cnt_d = cnt_q - CNT_W'(1); if (cnt_q == CNT_W'(1)) state_d = S_ACT;  end
         S_WAIT_RCD:  begin cnt_d = cnt_q - CNT_W'(1); if (cnt_q == CNT_W'(1)) state_d = S_RW;   end
         S_WAIT_DATA: begin cnt_d = cnt_q - CNT_W'(1); if (cnt_q == CNT_W'(1)) state_d = S_IDLE; end
         S_RWAIT_RP:  begin cnt_d = cnt_q - CNT_W'(1); if (cnt_q == CNT_W'(1)) state_d = S_REF;  end
         S_RWAIT_RFC: begin cnt_d = cnt_q - CNT_W'(1); if (cnt_q == CNT_W'(1)) state_d = S_IDLE; end
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      open_d = open_q;
      row_d  = row_q;
      unique case (state_q)
         S_ACT:   begin open_d[bank_q] = 1'b1; row_d[bank_q] = rrow_q; end
         S_PRE:   open_d[bank_q] = 1'b0;
         S_RW:    if (ap_q) open_d[bank_q] = 1'b0;
         S_RPREA: open_d = '0;
         default: ;
      endcase
      hit_d   = accept && lk_hit;
      empty_d = accept && !lk_open;
      miss_d  = accept && lk_open && !lk_hit;
      ack_d   = (state_q == S_RWAIT_RFC) && (cnt_q == CNT_W'(1));
      rw_d    = accept ? req_rw   : rw_q;
      ap_d    = accept ? req_ap   : ap_q;
      bank_d  = accept ? req_bank : bank_q;
      rrow_d  = accept ? req_row  : rrow_q;
      col_d   = accept ? req_col  : col_q;
      tag_d   = accept ? req_tag  : tag_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         open_q  <= '0;
         run_q   <= 1'b0;
         hit_q   <= 1'b0;
         empty_q <= 1'b0;
         miss_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         open_q  <= open_d;
         run_q   <= 1'b1;
         hit_q   <= hit_d;
         empty_q <= empty_d;
         miss_q  <= miss_d;
         ack_q   <= ack_d;
      end
   end

   always_ff @(posedge clock) begin
      row_q  <= row_d;
      rw_q   <= rw_d;
      ap_q   <= ap_d;
      bank_q <= bank_d;
      rrow_q <= rrow_d;
      col_q  <= col_d;
      tag_q  <= tag_d;
   end

   always_comb begin
      col_addr     = ROW_WIDTH'(col_q);
      col_addr[10] = ap_q;
      cmd_op       = OP_NOP;
      cmd_bg       = '0;
      cmd_ba       = '0;
      cmd_addr     = '0;
      unique case (state_q)
         S_PRE:   begin cmd_op = OP_PRE; cmd_bg = bank_q[BK_W-1:BA_WIDTH]; cmd_ba = bank_q[BA_WIDTH-1:0]; end
         S_ACT:   begin
            cmd_op   = OP_ACT;
            cmd_bg   = bank_q[BK_W-1:BA_WIDTH];
            cmd_ba   = bank_q[BA_WIDTH-1:0];
            cmd_addr = rrow_q;
         end
         S_RW:    begin
            cmd_op   = rw_q ? OP_RD : OP_WR;
            cmd_bg   = bank_q[BK_W-1:BA_WIDTH];
            cmd_ba   = bank_q[BA_WIDTH-1:0];
            cmd_addr = col_addr;
         end
         S_RPREA: begin cmd_op = OP_PREA; cmd_addr[10] = 1'b1; end
         S_REF:   cmd_op = OP_REF;
         default: ;
      endcase
      cmd_valid   = (cmd_op != OP_NOP);
      done        = (state_q == S_WAIT_DATA) && (cnt_q == CNT_W'(1));
      done_tag    = done ? tag_q : '0;
      req_ready   = run_q && (state_q == S_IDLE) && !refresh_req;
      refresh_ack = ack_q;
      page_hit    = hit_q;
      page_empty  = empty_q;
      page_miss   = miss_q;
   end

`ifdef DDR4_PERF_CNT_EN
   logic [31:0] perf_hit_q, perf_hit_d, perf_empty_q, perf_empty_d, perf_miss_q, perf_miss_d;

   always_comb begin
      perf_hit_d   = perf_hit_q;
      perf_empty_d = perf_empty_q;
      perf_miss_d  = perf_miss_q;
      if (hit_q   && perf_hit_q   != 32'hFFFF_FFFF) perf_hit_d   = perf_hit_q   + 32'd1;
      if (empty_q && perf_empty_q != 32'hFFFF_FFFF) perf_empty_d = perf_empty_q + 32'd1;
      if (miss_q  && perf_miss_q  != 32'hFFFF_FFFF) perf_miss_d  = perf_miss_q  + 32'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_hit_q   <= '0;
         perf_empty_q <= '0;
         perf_miss_q  <= '0;
      end else begin
         perf_hit_q   <= perf_hit_d;
         perf_empty_q <= perf_empty_d;
         perf_miss_q  <= perf_miss_d;
      end
   end

   assign perf_hit   = perf_hit_q;
   assign perf_empty = perf_empty_q;
   assign perf_miss  = perf_miss_q;
`else
   assign perf_hit   = '0;
   assign perf_empty = '0;
   assign perf_miss  = '0;
`endif

endmodule

// File: tb/tb_ddr4_bank_cmd_seq.sv
// Bench for ddr4_bank_cmd_seq: directed scenarios then random traffic against a table/schedule reference model.
module tb_ddr4_bank_cmd_seq;
   localparam int T_RP = 16, T_RCD = 16, T_CL = 16, T_CWL = 12, T_BL = 4, T_RFC = 32;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_rw, req_ap, refresh_req;
   logic [1:0]  req_bg, req_ba;
   logic [16:0] req_row;
   logic [9:0]  req_col;
   logic [3:0]  req_tag;
   logic        req_ready, refresh_ack, cmd_valid, done, page_hit, page_empty, page_miss;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_bg, cmd_ba;
   logic [16:0] cmd_addr;
   logic [3:0]  done_tag;
   logic [31:0] perf_hit, perf_empty, perf_miss;

   int tests = 0;
   int fails = 0;

   bit          m_open [16];
   logic [16:0] m_row  [16];
   int          m_hit, m_empty, m_miss;

   ddr4_bank_cmd_seq dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
      .req_ap(req_ap), .req_tag(req_tag),
      .refresh_req(refresh_req), .refresh_ack(refresh_ack),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
      .cmd_addr(cmd_addr), .done(done), .done_tag(done_tag),
      .page_hit(page_hit), .page_empty(page_empty), .page_miss(page_miss),
      .perf_hit(perf_hit), .perf_empty(perf_empty), .perf_miss(perf_miss)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
   endtask

   task automatic check_perf();
`ifdef DDR4_PERF_CNT_EN
      check("perf_hit", perf_hit, m_hit);
      check("perf_empty", perf_empty, m_empty);
      check("perf_miss", perf_miss, m_miss);
`else
      check("perf_hit", perf_hit, 0);
      check("perf_empty", perf_empty, 0);
      check("perf_miss", perf_miss, 0);
`endif
   endtask

   task automatic drive_req(input bit rw, input int bg, input int ba, input logic [16:0] row,
                            input logic [9:0] col, input bit ap, input logic [3:0] tag);
      req_rw  = rw;
      req_bg  = 2'(bg);
      req_ba  = 2'(ba);
      req_row = row;
      req_col = col;
      req_ap  = ap;
      req_tag = tag;
   endtask

   // Present one request in the current (idle) cycle and follow it to completion.
   task automatic run_req(input bit rw, input int bg, input int ba, input logic [16:0] row,
                          input logic [9:0] col, input bit ap, input logic [3:0] tag);
      int bank, cls, t_pre, t_act, t_rw, t_done, ebg, eba;
      logic [2:0]  eop;
      logic [16:0] eaddr;
      bank  = bg * 4 + ba;
      t_pre = -1;
      t_act = -1;
      if (!m_open[bank]) begin cls = 0; t_act = 0; t_rw = T_RCD; end
      else if (m_row[bank] == row) begin cls = 1; t_rw = 0; end
      else begin cls = 2; t_pre = 0; t_act = T_RP; t_rw = T_RP + T_RCD; end
      t_done = t_rw + (rw ? T_CL + T_BL : T_CWL + T_BL);
      drive_req(rw, bg, ba, row, col, ap, tag);
      req_valid = 1'b1;
      #1;
      check("req_ready_accept", req_ready, 1);
      step();
      req_valid = 1'b0;
      for (int k = 0; k <= t_done; k++) begin
         eop = 3'd0; eaddr = '0; ebg = 0; eba = 0;
         if (k == t_pre) begin eop = 3'd4; ebg = bg; eba = ba; end
         else if (k == t_act) begin eop = 3'd1; ebg = bg; eba = ba; eaddr = row; end
         else if (k == t_rw) begin
            eop = rw ? 3'd2 : 3'd3; ebg = bg; eba = ba;
            eaddr = {7'd0, col} | (ap ? 17'h400 : 17'h0);
         end
         check("cmd_valid", cmd_valid, eop != 3'd0);
         check("cmd_op", cmd_op, eop);
         check("cmd_bg", cmd_bg, ebg);
         check("cmd_ba", cmd_ba, eba);
         check("cmd_addr", cmd_addr, eaddr);
         check("page_empty", page_empty, k == 0 && cls == 0);
         check("page_hit", page_hit, k == 0 && cls == 1);
         check("page_miss", page_miss, k == 0 && cls == 2);
         check("done", done, k == t_done);
         check("done_tag", done_tag, (k == t_done) ? tag : 4'd0);
         check("req_ready_busy", req_ready, 0);
         step();
      end
      check("req_ready_after_done", req_ready, 1);
      m_open[bank] = !ap;
      m_row[bank]  = row;
      case (cls)
         0: m_empty++;
         1: m_hit++;
         default: m_miss++;
      endcase
   endtask

   // Raise refresh in the current idle cycle; returns in the ack cycle with refresh_req dropped.
   task automatic run_refresh();
      int t_prea, t_ref, t_ack;
      bit any;
      logic [2:0]  eop;
      logic [16:0] eaddr;
      any = 1'b0;
      for (int i = 0; i < 16; i++) any |= m_open[i];
      t_prea = any ? 0 : -1;
      t_ref  = any ? T_RP : 0;
      t_ack  = t_ref + T_RFC;
      refresh_req = 1'b1;
      #1;
      check("req_ready_refresh", req_ready, 0);
      step();
      for (int k = 0; k <= t_ack; k++) begin
         eop = 3'd0; eaddr = '0;
         if (k == t_prea) begin eop = 3'd5; eaddr = 17'h400; end
         else if (k == t_ref) eop = 3'd6;
         check("rf_cmd_valid", cmd_valid, eop != 3'd0);
         check("rf_cmd_op", cmd_op, eop);
         check("rf_cmd_addr", cmd_addr, eaddr);
         check("rf_cmd_bank", {cmd_bg, cmd_ba}, 0);
         check("refresh_ack", refresh_ack, k == t_ack);
         check("rf_done", done, 0);
         check("rf_pulses", {page_hit, page_empty, page_miss}, 0);
         if (k < t_ack) begin
            check("rf_req_ready", req_ready, 0);
            step();
         end
      end
      refresh_req = 1'b0;
      #1;
      check("req_ready_after_ack", req_ready, 1);
      model_clear();
   endtask

   initial begin
      logic [16:0] rows [3];
      int r;
      rows[0] = 17'h00100; rows[1] = 17'h00200; rows[2] = 17'h1FFFF;
      reset = 1'b0; req_valid = 1'b0; refresh_req = 1'b0;
      drive_req(0, 0, 0, 0, 0, 0, 0);
      model_clear();
      m_hit = 0; m_empty = 0; m_miss = 0;
      step(); step();
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd_op", cmd_op, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_done", done, 0);
      check("rst_ack", refresh_ack, 0);
      check_perf();
      reset = 1'b1;
      step();
      check("req_ready_out_of_reset", req_ready, 1);

      // 1..3: empty read, hit read, miss write with auto-precharge
      run_req(1, 1, 2, 17'h100, 10'h008, 0, 4'd3);
      run_req(1, 1, 2, 17'h100, 10'h008, 0, 4'd5);
      run_req(0, 1, 2, 17'h200, 10'h010, 1, 4'd7);
      check("entry_closed_after_ap", m_open[6], 0);
      check_perf();
      run_req(1, 1, 2, 17'h200, 10'h011, 0, 4'd8);

      // 4: refresh beats a simultaneous request while a bank is open
      run_req(1, 0, 0, 17'h055, 10'h3FF, 0, 4'd9);
      drive_req(1, 1, 2, 17'h300, 10'h020, 0, 4'd2);
      req_valid = 1'b1;
      run_refresh();
      run_req(1, 1, 2, 17'h300, 10'h020, 0, 4'd2);
      check("after_refresh_classified_empty", m_empty, 4);
      step();
      run_refresh();
      step();

      // 5: reset in WAIT_RCD aborts the access and closes the table
      drive_req(1, 2, 1, 17'h077, 10'h004, 0, 4'd11);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      check("s5_act", cmd_op, 1);
      step(); step(); step(); step();
      reset = 1'b0;
      #1;
      check("s5_cmd_valid", cmd_valid, 0);
      check("s5_cmd_op", cmd_op, 0);
      check("s5_cmd_addr", cmd_addr, 0);
      check("s5_done", done, 0);
      check("s5_req_ready", req_ready, 0);
      check("s5_pulses", {page_hit, page_empty, page_miss, refresh_ack}, 0);
      model_clear();
      m_hit = 0; m_empty = 0; m_miss = 0;
      check_perf();
      step();
      check("s5_done_held", done, 0);
      reset = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         check("s5_no_done", done, 0);
         check("s5_no_cmd", cmd_valid, 0);
         step();
      end
      run_req(1, 2, 1, 17'h077, 10'h004, 0, 4'd12);
      check("s5_reclassified_empty", m_empty, 1);

      // Random traffic over four banks and three rows
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 11);
         if (r == 0) begin
            run_refresh();
         end else if (r == 1) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
               step();
               check("gap_cmd_valid", cmd_valid, 0);
               check("gap_req_ready", req_ready, 1);
            end
         end else begin
            run_req($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1) * 3,
                    rows[$urandom_range(0, 2)], 10'($urandom), $urandom_range(0, 3) == 0,
                    4'($urandom));
         end
      end
      check_perf();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
